// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//
// Multiplexed LED matrix scan engine with a double-buffered frame store.
// One row is driven at a time for SCAN_DIV clock cycles (a "dwell"). The
// first BLANK_CYCLES of every dwell drive nothing, so the previous row's
// charge can drain before the next row turns on (anti-ghosting). Pixel
// data is written into a back bank while the front bank is displayed. A
// requested swap is held until the scan wraps from the last row to row 0,
// so a frame is never torn.
//
// Optional feature: define LED_SCAN_BRIGHTNESS_EN to gate the column drive
// with a free-running PWM counter compared against `brightness`. Without
// the macro, `brightness` is ignored and no PWM logic is built.
//
// Handshake: there is no backpressure anywhere. wr_en writes in the cycle it
// is high. swap_req is a one-cycle pulse; while a swap is pending, further
// pulses are absorbed.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   wr_en        write strobe into the back bank
//   wr_row       row address of the write (ignored when >= ROWS)
//   wr_data      row pixel data, bit c = column c, 1 = lit
//   swap_req     single-cycle front/back swap request
//   brightness   global duty setting (used only with LED_SCAN_BRIGHTNESS_EN)
//   row          one-hot active-high row drive (registered)
//   col          active-high column drive (registered)
//   frame_start  one-cycle pulse when the scan has wrapped to row 0
//   swap_done    one-cycle pulse when the bank swap has taken effect
module led_matrix_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int SCAN_DIV     = 27000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic                      swap_req,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [ROWS-1:0]           row,
    output logic [COLS-1:0]           col,
    output logic                      frame_start,
    output logic                      swap_done
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    localparam logic [DW-1:0] DCNT_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DCNT_BLANK = DW'(BLANK_CYCLES);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    // Swap request tracker.
    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    swap_state_t swap_state;
    swap_state_t swap_next;
    logic        swap_fire;

    // Scan position. `run` holds the counter still for the first edge after
    // reset release, so the scan restarts with a full blank phase and the
    // registered outputs lag the counter by exactly one cycle.
    logic            run;
    logic [DW-1:0]   dcnt;
    logic [RW-1:0]   row_idx;
    logic            last_dwell;
    logic            wrap;
    logic            active;

    // Frame store: bank_sel selects the displayed (front) bank.
    logic            bank_sel;
    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];
    logic [COLS-1:0] front_row;
    logic            wr_ok;
    logic            col_gate;

    assign last_dwell = (dcnt == DCNT_LAST);
    assign wrap       = run && last_dwell && (row_idx == ROW_LAST);
    assign active     = (dcnt >= DCNT_BLANK);
    assign front_row  = bank_sel ? bank1[row_idx] : bank0[row_idx];
    assign wr_ok      = wr_en && (int'(wr_row) < ROWS);

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [BRIGHT_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // All-ones brightness means always on; a plain compare would blank the
    // single cycle where pwm_cnt is also all-ones.
    assign col_gate = (brightness == {BRIGHT_W{1'b1}}) || (pwm_cnt < brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign col_gate          = 1'b1;
`endif

    // Swap tracker: next state and swap strobe.
    always_comb begin
        swap_next = swap_state;
        swap_fire = 1'b0;
        case (swap_state)
            SWAP_IDLE: begin
                if (swap_req) begin
                    swap_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (wrap) begin
                    swap_fire = 1'b1;
                    // A request landing in the wrap cycle itself waits for
                    // the next frame boundary.
                    swap_next = swap_req ? SWAP_PENDING : SWAP_IDLE;
                end
            end
            default: begin
                swap_next = SWAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_state <= SWAP_IDLE;
        end else begin
            swap_state <= swap_next;
        end
    end

    // Scan counters, bank select and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            run         <= 1'b0;
            dcnt        <= '0;
            row_idx     <= '0;
            bank_sel    <= 1'b0;
            row         <= '0;
            col         <= '0;
            frame_start <= 1'b0;
            swap_done   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (last_dwell) begin
                    dcnt    <= '0;
                    row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end

            if (swap_fire) begin
                bank_sel <= ~bank_sel;
            end

            row         <= active ? (ROWS'(1) << row_idx) : '0;
            col         <= active ? (front_row & {COLS{col_gate}}) : '0;
            frame_start <= wrap;
            swap_done   <= swap_fire;
        end
    end

    // Frame store writes always land in the back bank as it is before any
    // toggle in the same cycle, so data written in the swap cycle is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_ok) begin
            if (bank_sel) begin
                bank0[wr_row] <= wr_data;
            end else begin
                bank1[wr_row] <= wr_data;
            end
        end
    end

endmodule
